// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [clog2(DEPTH):0]  o_count
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_FULL);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/uart_core_param.sv
// Parametrised UART: baud tick generator, TX/RX FSMs, FIFOs, loopback and error pulses.
module uart_core_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [DATA_BITS-1:0]        i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic [DATA_BITS-1:0]        o_rx_data,
    output logic                        o_rx_valid,
    input  logic                        i_rx_ready,
    input  logic                        i_rxd,
    output logic                        o_txd,
    input  logic                        i_loopback,
    output logic [clog2(FIFO_DEPTH):0]  o_tx_count,
    output logic [clog2(FIFO_DEPTH):0]  o_rx_count,
    output logic                        o_tx_busy,
    output logic                        o_rx_frame_err,
    output logic                        o_rx_parity_err,
    output logic                        o_rx_overrun
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = clog2(DIV) + 1;
    localparam int OW      = clog2(OVERSAMPLE) + 1;
    localparam int BW      = clog2(DATA_BITS) + 1;
    localparam logic            PAR_INV  = (PARITY == PAR_ODD);
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0]   OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0]   OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_BITS - 1);
    localparam uart_state_e     ST_AFTER_DATA = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;

    logic [DW-1:0]        r_div_cnt;
    logic                 w_tick;
    logic                 w_txf_empty, w_txf_full, w_tx_pop;
    logic [DATA_BITS-1:0] w_txf_data;
    uart_state_e          r_tx_state, w_tx_nxt;
    logic [OW-1:0]        r_tx_tcnt;
    logic [BW-1:0]        r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par, r_tx_line, w_tx_last;
    logic                 r_rx_meta, r_rx_line;
    uart_state_e          r_rx_state, w_rx_nxt;
    logic [OW-1:0]        r_rx_tcnt;
    logic [BW-1:0]        r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par, r_rx_brk, w_rx_last, w_rx_half, w_rx_exp;
    logic                 w_rx_sample, w_rx_good, w_ferr, w_perr;
    logic                 w_rxf_empty, w_rxf_full, w_rx_pop;
    logic                 r_ferr, r_perr, r_ovr;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_div_cnt <= '0;
        else          r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),       .i_rst_n (i_rst_n),
        .i_push  (i_tx_valid && o_tx_ready), .i_wdata (i_tx_data),
        .i_pop   (w_tx_pop),    .o_rdata (w_txf_data),
        .o_full  (w_txf_full),  .o_empty (w_txf_empty), .o_count (o_tx_count)
    );

    assign o_tx_ready = !w_txf_full;
    assign o_tx_busy  = (r_tx_state != ST_IDLE) || !w_txf_empty;
    assign o_txd      = i_loopback ? 1'b1 : r_tx_line;
    assign w_tx_last  = (r_tx_tcnt == OS_LAST);

    always_comb begin
        w_tx_nxt = r_tx_state;
        w_tx_pop = 1'b0;
        case (r_tx_state)
            ST_IDLE:   if (w_tick && !w_txf_empty) begin w_tx_nxt = ST_START; w_tx_pop = 1'b1; end
            ST_START:  if (w_tick && w_tx_last) w_tx_nxt = ST_DATA;
            ST_DATA:   if (w_tick && w_tx_last && r_tx_bit == BIT_LAST) w_tx_nxt = ST_AFTER_DATA;
            ST_PARITY: if (w_tick && w_tx_last) w_tx_nxt = ST_STOP;
            ST_STOP:   if (w_tick && w_tx_last) begin
                // Chain straight into the next start bit so frames run back to back.
                if (!w_txf_empty) begin w_tx_nxt = ST_START; w_tx_pop = 1'b1; end
                else w_tx_nxt = ST_IDLE;
            end
            default:   w_tx_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_tcnt  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_nxt;
            if (r_tx_state == ST_IDLE) r_tx_tcnt <= '0;
            else if (w_tick)           r_tx_tcnt <= w_tx_last ? '0 : r_tx_tcnt + 1'b1;
            if (w_tx_pop) begin
                r_tx_shift <= w_txf_data;
                r_tx_par   <= (^w_txf_data) ^ PAR_INV;
            end else if (r_tx_state == ST_DATA && w_tick && w_tx_last) begin
                r_tx_shift <= r_tx_shift >> 1;
            end
            if (r_tx_state != ST_DATA)   r_tx_bit <= '0;
            else if (w_tick && w_tx_last) r_tx_bit <= r_tx_bit + 1'b1;
            case (r_tx_state)
                ST_START:  r_tx_line <= 1'b0;
                ST_DATA:   r_tx_line <= r_tx_shift[0];
                ST_PARITY: r_tx_line <= r_tx_par;
                default:   r_tx_line <= 1'b1;
            endcase
        end
    end

    assign w_rx_last = (r_rx_tcnt == OS_LAST);
    assign w_rx_half = (r_rx_tcnt == OS_HALF);
    assign w_rx_exp  = (^r_rx_shift) ^ PAR_INV;
    assign w_rx_pop  = !w_rxf_empty && i_rx_ready;

    always_comb begin
        w_rx_nxt    = r_rx_state;
        w_rx_sample = 1'b0;
        w_rx_good   = 1'b0;
        w_ferr      = 1'b0;
        w_perr      = 1'b0;
        case (r_rx_state)
            ST_IDLE:   if (!r_rx_line) w_rx_nxt = ST_START;
            ST_START:  if (w_tick && w_rx_half) w_rx_nxt = r_rx_line ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_tick && w_rx_last) begin
                w_rx_sample = 1'b1;
                if (r_rx_bit == BIT_LAST) w_rx_nxt = ST_AFTER_DATA;
            end
            ST_PARITY: if (w_tick && w_rx_last) w_rx_nxt = ST_STOP;
            ST_STOP:   if (r_rx_brk) begin
                // After a framing error, hold here until the line is released.
                if (r_rx_line) w_rx_nxt = ST_IDLE;
            end else if (w_tick && w_rx_last) begin
                if (!r_rx_line) w_ferr = 1'b1;
                else begin
                    w_rx_nxt = ST_IDLE;
                    if (PARITY != PAR_NONE && r_rx_par != w_rx_exp) w_perr = 1'b1;
                    else w_rx_good = 1'b1;
                end
            end
            default:   w_rx_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_line  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_tcnt  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_brk   <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_rx_meta  <= i_loopback ? r_tx_line : i_rxd;
            r_rx_line  <= r_rx_meta;
            r_rx_state <= w_rx_nxt;
            if (r_rx_state == ST_IDLE || (r_rx_state == ST_START && w_tick && w_rx_half))
                r_rx_tcnt <= '0;
            else if (w_tick)
                r_rx_tcnt <= w_rx_last ? '0 : r_rx_tcnt + 1'b1;
            if (w_rx_sample) r_rx_shift <= {r_rx_line, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_state == ST_PARITY && w_tick && w_rx_last) r_rx_par <= r_rx_line;
            if (r_rx_state != ST_DATA) r_rx_bit <= '0;
            else if (w_rx_sample)      r_rx_bit <= r_rx_bit + 1'b1;
            if (w_ferr)                     r_rx_brk <= 1'b1;
            else if (r_rx_state != ST_STOP) r_rx_brk <= 1'b0;
            r_ferr <= w_ferr;
            r_perr <= w_perr;
            r_ovr  <= w_rx_good && w_rxf_full && !w_rx_pop;
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),       .i_rst_n (i_rst_n),
        .i_push  (w_rx_good),   .i_wdata (r_rx_shift),
        .i_pop   (i_rx_ready),  .o_rdata (o_rx_data),
        .o_full  (w_rxf_full),  .o_empty (w_rxf_empty), .o_count (o_rx_count)
    );

    assign o_rx_valid      = !w_rxf_empty;
    assign o_rx_frame_err  = r_ferr;
    assign o_rx_parity_err = r_perr;
    assign o_rx_overrun    = r_ovr;
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised, single-clock UART core and successor to the fixed 8N1 top level.
- Integrates a fractional-free baud tick generator, an oversampled RX with start-bit glitch rejection, and a TX with optional parity.
- TX and RX FIFOs present ready/valid interfaces to the fabric.
- Adds internal loopback plus frame, parity and overrun error reporting.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate
OVERSAMPLE, 16, ticks per bit; even, >=8
DATA_BITS, 8, payload bits per frame, 5..9
PARITY, 0, 0=none, 1=even, 2=odd
FIFO_DEPTH, 16, entries per FIFO; power of two, >=2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_BITS  head of RX FIFO (first-word fall-through)
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  consumer pops head
rxd  in  1  serial input (asynchronous)
txd  out  1  serial output
loopback  in  1  route internal TX serial to RX
tx_count  out  log2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_count  out  log2(FIFO_DEPTH)+1  RX FIFO occupancy
tx_busy  out  1  TX FSM not IDLE or TX FIFO non-empty
rx_frame_err  out  1  1-cycle pulse
rx_parity_err  out  1  1-cycle pulse
rx_overrun  out  1  1-cycle pulse

Behaviour:
Reset values:
- txd=1; tx_ready=1; rx_valid=0; tx_busy=0; all error pulses 0; counts 0.
- Both FSMs in IDLE; RX synchroniser flops =1; tick counter 0.

Baud tick generator:
- DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer division, minimum 1.
- Free-running counter 0..DIV-1; tick is a 1-cycle strobe when the counter reaches DIV-1.

FIFOs:
- Push on valid&&ready; pop on rx_valid&&rx_ready.
- Simultaneous push+pop on a full FIFO: both occur, count unchanged.
- On an empty FIFO only the push occurs.
- Pointers wrap modulo FIFO_DEPTH.

TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- Leaves IDLE on the first tick with the TX FIFO non-empty; pops the FIFO into the shift register in that same cycle.
- Each state lasts OVERSAMPLE ticks; txd is registered.
- DATA is sent LSB first for DATA_BITS bits.
- Parity bit = XOR of data (even), inverted for odd.
- One stop bit. Back-to-back frames carry no idle gap.

RX path:
- Input is a 2-flop synchroniser on rxd, or on the internal TX serial when loopback=1.
- When loopback=1, txd is forced to 1.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
- IDLE waits for a synchronised falling level (line=0), then resets the tick phase counter.
- START samples at tick OVERSAMPLE/2. If the line is 1, it is a glitch: return to IDLE, no error.
- DATA and PARITY sample every OVERSAMPLE ticks from the START sample point.
- STOP samples the stop bit, with two outcomes:
  - Stop bit 0: rx_frame_err pulse, byte discarded, FSM waits for line=1 before returning to IDLE.
  - Parity mismatch (checked only when the stop bit is good): rx_parity_err pulse, byte discarded.
- A good frame pushes the byte at the stop sample; rx_valid rises the next cycle if the FIFO was empty.
- If the RX FIFO is full with no pop that cycle: rx_overrun pulse, new byte dropped, FIFO contents intact.

Reset mid-operation: all of the above return to reset values immediately (asynchronous); any partial frame is lost.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE, PAR_EVEN, PAR_ODD
  - TX/RX state enumerations IDLE, START, DATA, PARITY, STOP
  - a clog2 helper function
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; FWFT, count output) is instantiated twice.
- Baud generator, TX FSM and RX FSM stay in uart_core_param.

Test Plan:
All tests use CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16 (DIV=1, 16 cycles/bit).

1. PARITY=0, loopback=1, push 0xA5 -> txd stays 1 throughout; rx_data=0xA5, rx_valid=1 about 160 cycles after push; tx_busy falls after the stop bit.
2. PARITY=1, drive rxd with 0x3C, parity bit 0 -> rx_data=0x3C. Repeat with parity bit 1 -> rx_parity_err single pulse, rx_valid stays 0.
3. Drive 0x55 with stop bit 0 -> rx_frame_err pulse, rx_count=0. Then line high and a valid 0x12 -> rx_data=0x12.
4. rxd low for 4 cycles, then high -> no error pulse, rx_count=0, FSM returns to IDLE.
5. rx_ready=0, loopback=1, push FIFO_DEPTH+1 bytes 0x00..0x10 -> rx_count=16, one rx_overrun pulse; draining yields 0x00..0x0F in order.
6. Push 3 bytes, assert rst_n=0 during the second frame's DATA bits -> txd=1 and both counts 0 while in reset; no further frame after release.
